// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Instruction assembler and loader for the single-cycle MIPS datapath.
//   Each accepted symbolic request (op_sel plus register, immediate and target
//   fields) is encoded into a 32-bit MIPS word. The word is written into
//   instruction memory at successive word addresses through a synchronous
//   write port. The opcode set matches the main control decoder: R-type, beq,
//   sw, lw, addi, j, bne and lui.
//
// Parameters:
//   ADDR_W     instruction-memory word-address width, DEPTH = 2**ADDR_W
//   BASE_ADDR  first word address written after reset/clear (< 2**ADDR_W)
//
// Optional feature macro:
//   INSTR_ENCODER_END_PAD_EN  when defined, finish fills the remaining memory
//                             with nop words (32'h0) before reporting done.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   clear            synchronous restart (pointer, count, err, done cleared)
//   req_valid/ready  request handshake; ready depends on registered state only
//   op_sel           0=R 1=beq 2=sw 3=lw 4=addi 5=j 6=bne 7=lui
//   rs, rt, rd       register fields (rd used by R-type only)
//   funct            R-type function code
//   imm              16-bit immediate / branch word offset
//   target           26-bit jump target word field
//   finish           end-of-program request
//   imem_we/addr/wdata  registered instruction-memory write port
//   count            words written since reset/clear
//   done             program load complete
//   err              sticky flag: illegal R-type funct seen
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE_C = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE_C = (ADDR_W + 1)'(1);

`ifdef INSTR_ENCODER_END_PAD_EN
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_PAD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd2
    } state_e;
`endif

    // Builds the 32-bit MIPS word for the selected operation.
    function automatic logic [31:0] encode_word(
        input logic [2:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'h00, f_rs, f_rt, f_rd, 5'b00000, f_funct};
            3'd1:    w = {6'h04, f_rs, f_rt, f_imm};
            3'd2:    w = {6'h2B, f_rs, f_rt, f_imm};
            3'd3:    w = {6'h23, f_rs, f_rt, f_imm};
            3'd4:    w = {6'h08, f_rs, f_rt, f_imm};
            3'd5:    w = {6'h02, f_target};
            3'd6:    w = {6'h05, f_rs, f_rt, f_imm};
            3'd7:    w = {6'h0F, 5'b00000, f_rt, f_imm};  // lui ignores rs
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // True for the R-type function codes the datapath's ALU supports.
    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              finish_seen_q, finish_seen_d;

    logic              ready_s;
    logic              accept_s;
    logic              legal_s;
    logic [31:0]       word_s;

    // Handshake and encoding, derived from registered state and inputs.
    always_comb begin
        ready_s  = (state_q == ST_LOAD) && (count_q < DEPTH_C) && !finish_seen_q;
        accept_s = req_valid && ready_s;
        legal_s  = (op_sel != 3'd0) || funct_legal(funct);
        word_s   = encode_word(op_sel, rs, rt, rd, funct, imm, target);
    end

    // Next-state logic for the load FSM and the registered write port.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        done_d        = done_q;
        err_d         = err_q;
        finish_seen_d = finish_seen_q;

        if (clear) begin
            state_d       = ST_LOAD;
            ptr_d         = BASE_C;
            count_d       = '0;
            done_d        = 1'b0;
            err_d         = 1'b0;
            finish_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // An illegal R-type still completes its handshake but
                    // only raises err; pointer and count stay put.
                    if (accept_s) begin
                        if (legal_s) begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = word_s;
                            ptr_d   = ptr_q + PTR_ONE_C;
                            count_d = count_q + CNT_ONE_C;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        we_d = 1'b0;
                    end

                    // finish is latched first and acted on one edge later so
                    // that a coincident request is written before leaving LOAD.
                    if (finish_seen_q) begin
`ifdef INSTR_ENCODER_END_PAD_EN
                        if (count_q < DEPTH_C) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (finish) begin
                        finish_seen_d = 1'b1;
                    end else begin
                        finish_seen_d = 1'b0;
                    end
                end
`ifdef INSTR_ENCODER_END_PAD_EN
                ST_PAD: begin
                    if (count_q < DEPTH_C) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = 32'h0000_0000;
                        ptr_d   = ptr_q + PTR_ONE_C;
                        count_d = count_q + CNT_ONE_C;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            ptr_q         <= BASE_C;
            count_q       <= '0;
            we_q          <= 1'b0;
            addr_q        <= BASE_C;
            wdata_q       <= 32'h0000_0000;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            finish_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            done_q        <= done_d;
            err_q         <= err_d;
            finish_seen_q <= finish_seen_d;
        end
    end

    assign req_ready  = ready_s;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Scoreboard bench for instr_encoder (ADDR_W=2, BASE_ADDR=0). Expected
// {address, word} pairs are queued when a request is driven and popped by a
// monitor whenever imem_we is seen high. Honours INSTR_ENCODER_END_PAD_EN.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    op_sel = 3'd0;
    logic [4:0]    rs = 5'd0;
    logic [4:0]    rt = 5'd0;
    logic [4:0]    rd = 5'd0;
    logic [5:0]    funct = 6'd0;
    logic [15:0]   imm = 16'd0;
    logic [25:0]   target = 26'd0;
    logic          finish = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_sel     (op_sel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .finish     (finish),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  m_ptr = '0;
    logic [AW:0]    m_cnt = '0;
    int             we_run = 0;
    int             max_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (imem_we === 1'b1) begin
            we_run++;
            if (we_run > max_run) max_run = we_run;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(imem_addr), 32'(e[AW+31:32]));
                check_eq("wr_data", imem_wdata, e[31:0]);
            end
        end else begin
            we_run = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                         input logic [25:0] tg, input logic [31:0] word, input bit legal);
        int n;
        @(negedge clk);
        op_sel = op; rs = s; rt = t; rd = d; funct = f; imm = im; target = tg;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            if (legal) begin
                exp_q.push_back({m_ptr, word});
                m_ptr = m_ptr + 2'd1;
                m_cnt = m_cnt + 3'd1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        req_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_ptr = '0;
        m_cnt = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        #12;
        check_eq("rst_we", 32'(imem_we), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);

        // addi rs=1 rt=2 imm=5
        issue(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h2022_0005, 1'b1);
        idle();

        // R add then j, back-to-back
        do_clear();
        max_run = 0;
        issue(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'd0, 32'h0022_1820, 1'b1);
        issue(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h000_0010, 32'h0800_0010, 1'b1);
        idle();
        @(negedge clk);
        check_eq("b2b_we_run", 32'(max_run), 32'd2);

        // lw / bne / lui (rs forced to 0)
        do_clear();
        issue(3'd3, 5'd0, 5'd4, 5'd0, 6'd0, 16'h0008, 26'd0, 32'h8C04_0008, 1'b1);
        issue(3'd6, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 32'h1422_FFFE, 1'b1);
        issue(3'd7, 5'd7, 5'd5, 5'd0, 6'd0, 16'h1234, 26'd0, 32'h3C05_1234, 1'b1);
        idle();
        check_eq("count_3", 32'(count), 32'(m_cnt));

        // Fill: 5 held requests into a 4-word memory
        do_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_sel = 3'd4; rs = 5'd0; rt = 5'd1; imm = 16'(i);
            req_valid = 1'b1;
            check_eq("full_ready", 32'(req_ready), 32'(m_cnt < 3'd4));
            if (m_cnt < 3'd4) begin
                exp_q.push_back({m_ptr, 32'h2001_0000 + 32'(i)});
                m_ptr = m_ptr + 2'd1;
                m_cnt = m_cnt + 3'd1;
            end
            @(posedge clk);
            #1;
        end
        idle();
        @(negedge clk);
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_ready_low", 32'(req_ready), 32'd0);

        // Illegal funct, then legal at same address, then clear
        do_clear();
        issue(3'd0, 5'd1, 5'd2, 5'd3, 6'h08, 16'h0000, 26'd0, 32'h0, 1'b0);
        idle();
        check_eq("illegal_err", 32'(err), 32'd1);
        check_eq("illegal_count", 32'(count), 32'd0);
        issue(3'd0, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h0000, 26'd0, 32'h0085_302A, 1'b1);
        idle();
        check_eq("err_sticky", 32'(err), 32'd1);
        do_clear();
        check_eq("clear_err", 32'(err), 32'd0);
        check_eq("clear_count", 32'(count), 32'd0);
        issue(3'd1, 5'd3, 5'd3, 5'd0, 6'd0, 16'h0001, 26'd0, 32'h1063_0001, 1'b1);
        idle();

        // Two writes then finish
        do_clear();
        issue(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0, 32'hAC22_0004, 1'b1);
        issue(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'h7FFF, 26'd0, 32'h2008_7FFF, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        check_eq("fin_ready_low", 32'(req_ready), 32'd0);
`ifdef INSTR_ENCODER_END_PAD_EN
        exp_q.push_back({2'd2, 32'h0});
        exp_q.push_back({2'd3, 32'h0});
        wait_done();
        check_eq("pad_count", 32'(count), 32'd4);
`else
        @(negedge clk);
        check_eq("fin_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_eq("fin_done", 32'(done), 32'd1);
        check_eq("fin_count", 32'(count), 32'd2);
`endif
        @(negedge clk);
        check_eq("done_hold", 32'(done), 32'd1);
        check_eq("done_ready", 32'(req_ready), 32'd0);

        // Reset in the middle of a write burst
        do_clear();
        check_eq("clear_done", 32'(done), 32'd0);
`ifdef INSTR_ENCODER_END_PAD_EN
        issue(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 32'h2001_0001, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        exp_q.push_back({2'd1, 32'h0});
        exp_q.push_back({2'd2, 32'h0});
        exp_q.push_back({2'd3, 32'h0});
        n = 0;
        while (!imem_we && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("pad_we_seen", 32'(imem_we), 32'd1);
`else
        issue(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 32'h2001_0001, 1'b1);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_we", 32'(imem_we), 32'd0);
        check_eq("midrst_count", 32'(count), 32'd0);
        exp_q.delete();
        m_ptr = '0;
        m_cnt = '0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", 32'(done), 32'd0);
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
